// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam int NIB_W = 4;
   localparam logic [NIB_W-1:0] BLANK_CODE = 4'hF;

   // Largest value representable in n decimal digits: 10**n - 1.
   function automatic longint unsigned max_val(input int unsigned n);
      longint unsigned p;
      p = 1;
      for (int unsigned i = 0; i < n; i++) begin
         p = p * 10;
      end
      return p - 1;
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the shift.
module bcd_add3
   import bin_to_bcd_pkg::*;
(
   input  logic [NIB_W-1:0] nib,
   output logic [NIB_W-1:0] res
);

   always_comb begin
      res = (nib >= 4'd5) ? nib + 4'd3 : nib;
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with saturation on overflow.
// Optional leading-zero blanking is enabled by defining BIN_TO_BCD_BLANK_EN.
module bin_to_bcd_seq
   import bin_to_bcd_pkg::*;
#(
   parameter int unsigned BIN_W    = 14,
   parameter int unsigned N_DIGITS = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      START,
   input  logic [BIN_W-1:0]          BIN,
   output logic                      BUSY,
   output logic                      DONE,
   output logic [NIB_W*N_DIGITS-1:0] BCD_OUT,
   output logic                      OVF
);

   localparam int unsigned BCD_W = NIB_W * N_DIGITS;
   localparam int unsigned CNT_W = $clog2(BIN_W);
   localparam logic [63:0] MAX_VAL = max_val(N_DIGITS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

   // Formats a plain BCD value for display; identity unless blanking is built in.
   function automatic logic [BCD_W-1:0] fmt(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
`ifdef BIN_TO_BCD_BLANK_EN
      logic lead;
`endif
      r = v;
`ifdef BIN_TO_BCD_BLANK_EN
      lead = 1'b1;
      for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
         if (lead && (v[i*NIB_W +: NIB_W] == 4'h0)) begin
            r[i*NIB_W +: NIB_W] = BLANK_CODE;
         end else begin
            lead = 1'b0;
         end
      end
`endif
      return r;
   endfunction

   localparam logic [BCD_W-1:0] RESET_BCD = fmt({BCD_W{1'b0}});

   state_t                 state_q, state_d;
   logic [BIN_W-1:0]       bin_q;
   logic [BCD_W-1:0]       scratch_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   ovf_pend_q;
   logic [BCD_W-1:0]       adj;
   logic [BCD_W+BIN_W-1:0] sh;
   logic [BCD_W-1:0]       scratch_nxt;
   logic [BIN_W-1:0]       bin_nxt;
   logic [BCD_W-1:0]       result;
   logic                   accept;
   logic                   finish;

   for (genvar i = 0; i < N_DIGITS; i++) begin : g_add3
      bcd_add3 u_add3 (
         .nib (scratch_q[i*NIB_W +: NIB_W]),
         .res (adj[i*NIB_W +: NIB_W])
      );
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (START) state_d = SHIFT;
         SHIFT:   if (cnt_q == LAST) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      BUSY   = (state_q == SHIFT);
      accept = (state_q == IDLE) && START;
      finish = (state_q == SHIFT) && (cnt_q == LAST);
   end

   always_comb begin
      sh          = {adj, bin_q} << 1;
      scratch_nxt = sh[BCD_W+BIN_W-1:BIN_W];
      bin_nxt     = sh[BIN_W-1:0];
      // Overflowed values saturate to all nines and are never blanked.
      if (ovf_pend_q) begin
         result = {N_DIGITS{4'h9}};
      end else begin
         result = fmt(scratch_nxt);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         bin_q      <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
      end else if (accept) begin
         bin_q      <= BIN;
         scratch_q  <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= (64'(BIN) > MAX_VAL);
      end else if (state_q == SHIFT) begin
         bin_q     <= bin_nxt;
         scratch_q <= scratch_nxt;
         cnt_q     <= cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         DONE    <= 1'b0;
         OVF     <= 1'b0;
         BCD_OUT <= RESET_BCD;
      end else begin
         DONE <= finish;
         if (finish) begin
            OVF     <= ovf_pend_q;
            BCD_OUT <= result;
         end
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (default 14-bit, 4-digit build).
module tb_bin_to_bcd_seq;

   localparam int BIN_W = 14;
   localparam int LIMIT = 40;

   logic        clk;
   logic        rst;
   logic        start;
   logic [13:0] bin;
   logic        busy;
   logic        done;
   logic [15:0] bcd_out;
   logic        ovf;

   int n_tests = 0;
   int n_fail  = 0;
   int lat;
   int dones;

   bin_to_bcd_seq #(.BIN_W(14), .N_DIGITS(4)) dut (
      .CLK     (clk),
      .RST     (rst),
      .START   (start),
      .BIN     (bin),
      .BUSY    (busy),
      .DONE    (done),
      .BCD_OUT (bcd_out),
      .OVF     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef BIN_TO_BCD_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   function automatic logic [31:0] pick(input logic [15:0] plain, input logic [15:0] blanked);
      return BLANK ? {16'h0, blanked} : {16'h0, plain};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Presents a request and returns #1 after the edge that accepts it.
   task automatic start_conv(input logic [13:0] val);
      bin   = val;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      bin   = 14'h2AAA;
   endtask

   // Counts edges until DONE is seen; returns LIMIT+1 on timeout.
   task automatic wait_done(output int n);
      n = LIMIT + 1;
      for (int i = 1; i <= LIMIT; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic run(input string tag, input logic [13:0] val, input logic [15:0] exp_bcd,
                      input logic exp_ovf);
      start_conv(val);
      check({tag, "_busy"}, {31'h0, busy}, 32'd1);
      wait_done(lat);
      check({tag, "_lat"}, lat, BIN_W);
      check({tag, "_bcd"}, {16'h0, bcd_out}, {16'h0, exp_bcd});
      check({tag, "_ovf"}, {31'h0, ovf}, {31'h0, exp_ovf});
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      bin   = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_busy", {31'h0, busy}, 32'd0);
      check("rst_done", {31'h0, done}, 32'd0);
      check("rst_ovf", {31'h0, ovf}, 32'd0);
      check("rst_bcd", {16'h0, bcd_out}, pick(16'h0000, 16'hFFF0));

      dones = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      check("idle_no_done", dones, 0);

      run("c1234", 14'd1234, 16'h1234, 1'b0);
      @(posedge clk);
      #1;
      check("done_pulse", {31'h0, done}, 32'd0);
      check("hold_bcd", {16'h0, bcd_out}, 32'h1234);

      run("c9999", 14'd9999, 16'h9999, 1'b0);
      run("c0", 14'd0, 16'h0000 | (BLANK ? 16'hFFF0 : 16'h0), 1'b0);
      run("c10000", 14'd10000, 16'h9999, 1'b1);
      run("c16383", 14'd16383, 16'h9999, 1'b1);
      run("c42", 14'd42, BLANK ? 16'hFF42 : 16'h0042, 1'b0);
      run("c1005", 14'd1005, 16'h1005, 1'b0);
      run("c900", 14'd900, BLANK ? 16'hF900 : 16'h0900, 1'b0);

      // A second START during the conversion must be ignored.
      start_conv(14'd1234);
      repeat (5) @(posedge clk);
      #1;
      bin   = 14'd42;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat);
      check("ign_lat", lat, 8);
      check("ign_bcd", {16'h0, bcd_out}, 32'h1234);
      @(posedge clk);
      #1;
      check("ign_busy", {31'h0, busy}, 32'd0);

      // Reset mid-conversion aborts it without a DONE.
      start_conv(14'd1234);
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mrst_busy", {31'h0, busy}, 32'd0);
      check("mrst_done", {31'h0, done}, 32'd0);
      check("mrst_bcd", {16'h0, bcd_out}, pick(16'h0000, 16'hFFF0));
      check("mrst_ovf", {31'h0, ovf}, 32'd0);
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      check("mrst_no_done", dones, 0);

      // Back-to-back: START in the DONE cycle is accepted.
      run("b2b_a", 14'd1234, 16'h1234, 1'b0);
      run("b2b_b", 14'd7, BLANK ? 16'hFFF7 : 16'h0007, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
